// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state type and counter-width helpers for the modexp core.
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, PRE, LOAD, WAIT, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  localparam int DEF_WIDTH = 256;
  localparam int PRE_CW = cnt_w(DEF_WIDTH + 1);
  localparam int BIT_CW = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: bit-serial Montgomery multiply, result = a*b*2^-WIDTH mod n.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish
);
  localparam int CW = cnt_w(WIDTH + 1);
  logic [WIDTH+1:0] acc, sum, red;
  logic [WIDTH-1:0] x, y;
  logic [CW-1:0] cnt;
  logic run;
  // acc stays below 2n, so a single subtract brings the result under n
  always_comb begin
    sum = acc + (x[0] ? {2'b0, y} : '0);
    red = sum + (sum[0] ? {2'b0, i_n} : '0);
    o_result = WIDTH'(acc >= {2'b0, i_n} ? acc - {2'b0, i_n} : acc);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run <= 1'b0;
      o_finish <= 1'b0;
    end else begin
      o_finish <= run && cnt == CW'(WIDTH - 1);
      if (i_start) begin
        acc <= '0;
        x <= i_a;
        y <= i_b;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        acc <= red >> 1;
        x <= x >> 1;
        cnt <= cnt + 1'b1;
        run <= cnt != CW'(WIDTH - 1);
      end
    end
  end
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: LSB-first Montgomery modular exponentiation a^e mod n.
// Define RSA_MODEXP_EARLY_EXIT_EN to stop once the remaining exponent bits are zero.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_src_val,
  output logic                 o_src_rdy,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [EXP_WIDTH-1:0] i_e,
  input  logic [WIDTH-1:0]     i_n,
  output logic                 o_result_val,
  input  logic                 i_result_rdy,
  output logic [WIDTH-1:0]     o_a_pow_e,
  output logic                 o_busy
);
  localparam int PW = cnt_w(WIDTH + 1);
  localparam int BW = cnt_w(EXP_WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] t, m, n, sq_res, mul_res;
  logic [EXP_WIDTH-1:0] e;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bitc;
  logic [WIDTH:0] t2;
  logic sq_start, mul_start, sq_done, mul_done, e_bit, last, skip;
  assign t2 = {t, 1'b0};
  assign e_bit = e[bitc];
`ifdef RSA_MODEXP_EARLY_EXIT_EN
  assign last = ((e >> bitc) >> 1) == '0;
  assign skip = e == '0;
`else
  assign last = bitc == BW'(EXP_WIDTH - 1);
  assign skip = 1'b0;
`endif
  assign o_a_pow_e = state == DONE ? m : '0;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    sq_start = 1'b0;
    mul_start = 1'b0;
    o_src_rdy = 1'b0;
    o_result_val = 1'b0;
    case (state)
      IDLE: begin
        o_src_rdy = 1'b1;
        if (i_src_val) nxt = PRE;
      end
      PRE:  if (pcnt == PW'(WIDTH - 1)) nxt = skip ? DONE : LOAD;
      LOAD: begin
        sq_start = 1'b1;
        mul_start = e_bit;
        nxt = WAIT;
      end
      WAIT: if (sq_done) nxt = last ? DONE : LOAD;
      DONE: begin
        o_result_val = 1'b1;
        if (i_result_rdy) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // t holds a^(2^bit) in Montgomery form; m stays in the plain domain
  always_ff @(posedge i_clk) begin
    case (state)
      IDLE: if (i_src_val) begin
        t <= i_a;
        e <= i_e;
        n <= i_n;
        pcnt <= '0;
        bitc <= '0;
      end
      PRE: begin
        t <= WIDTH'(t2 >= {1'b0, n} ? t2 - {1'b0, n} : t2);
        pcnt <= pcnt + 1'b1;
        m <= WIDTH'(1);
      end
      WAIT: if (sq_done) begin
        t <= sq_res;
        if (mul_done) m <= mul_res;
        bitc <= bitc + 1'b1;
      end
      default: ;
    endcase
  end
  rsa_mont_mul #(.WIDTH(WIDTH)) u_sq (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(sq_start), .i_n(n),
    .i_a(t), .i_b(t), .o_result(sq_res), .o_finish(sq_done)
  );
  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(mul_start), .i_n(n),
    .i_a(m), .i_b(t), .o_result(mul_res), .o_finish(mul_done)
  );
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed and small-model checks of the 8-bit modexp core.
module tb_rsa_modexp_core;
  localparam int W = 8;
  localparam int EW = 8;
  logic clk = 0, rst = 1, src_val = 0, res_rdy = 0;
  logic src_rdy, res_val, busy;
  logic [W-1:0] a = '0, n = '0, res;
  logic [EW-1:0] e = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .i_clk(clk), .i_rst(rst), .i_src_val(src_val), .o_src_rdy(src_rdy),
    .i_a(a), .i_e(e), .i_n(n), .o_result_val(res_val), .i_result_rdy(res_rdy),
    .o_a_pow_e(res), .o_busy(busy)
  );
  task automatic check(input string tag, input longint got, input longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask
  function automatic longint modpow(input longint b, input longint x, input longint m);
    longint r = 1;
    b = b % m;
    while (x > 0) begin
      if (x[0]) r = (r * b) % m;
      b = (b * b) % m;
      x = x >> 1;
    end
    return r % m;
  endfunction
  function automatic int exp_lat(input logic [EW-1:0] x);
    int nb = EW;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    nb = 0;
    for (int i = 0; i < EW; i++) if (x[i]) nb = i + 1;
`endif
    return W + 1 + nb * (W + 2);
  endfunction
  task automatic issue(input logic [W-1:0] aa, input logic [EW-1:0] ee, input logic [W-1:0] nn);
    @(negedge clk);
    check("src_rdy_before_issue", src_rdy, 1);
    a = aa;
    e = ee;
    n = nn;
    src_val = 1;
    @(posedge clk);
    #1 src_val = 0;
  endtask
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!res_val && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask
  task automatic run(input string tag, input logic [W-1:0] aa, input logic [EW-1:0] ee,
                     input logic [W-1:0] nn, input longint expv);
    int cyc;
    issue(aa, ee, nn);
    wait_result(cyc);
    check({tag, "_val"}, res_val, 1);
    check({tag, "_lat"}, cyc, exp_lat(ee));
    check({tag, "_res"}, res, expv);
    res_rdy = 1;
    @(posedge clk);
    #1 res_rdy = 0;
    check({tag, "_rdy_after"}, src_rdy, 1);
  endtask
  initial begin
    int cyc;
    logic ok;
    logic [W-1:0] ra, rn;
    logic [EW-1:0] re;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_src_rdy", src_rdy, 1);
    check("rst_val", res_val, 0);
    check("rst_out", res, 0);
    check("rst_busy", busy, 0);
    run("a5e3n33", 5, 3, 33, 26);
    run("a2e7n143", 2, 7, 143, 128);
    run("a0e5n143", 0, 5, 143, 0);
    run("a7e0n143", 7, 0, 143, 1);
    run("a142e255n143", 142, 255, 143, 142);
    // back-pressure: result held, new request ignored
    issue(5, 3, 33);
    wait_result(cyc);
    check("bp_val", res_val, 1);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a = 2;
        e = 7;
        n = 143;
        src_val = 1;
      end
      if (!(res_val && res == 26 && !src_rdy && busy)) ok = 0;
    end
    check("bp_stable", ok, 1);
    src_val = 0;
    res_rdy = 1;
    @(posedge clk);
    #1 res_rdy = 0;
    check("bp_src_rdy", src_rdy, 1);
    check("bp_val_low", res_val, 0);
    repeat (5) @(posedge clk);
    #1 check("bp_no_ghost", busy, 0);
    // reset during WAIT of bit 2
    issue(5, 3, 33);
    repeat (32) @(posedge clk);
    #1 check("mid_busy", busy, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_src_rdy", src_rdy, 1);
    check("mid_rst_val", res_val, 0);
    ok = 0;
    repeat (120) begin
      @(posedge clk);
      #1 if (res_val || busy) ok = 1;
    end
    check("mid_rst_quiet", ok, 0);
    run("after_rst", 5, 3, 33, 26);
    for (int i = 0; i < 12; i++) begin
      rn = W'($urandom_range(1, 127) * 2 + 1);
      ra = W'($urandom_range(0, int'(rn) - 1));
      re = EW'($urandom_range(0, 255));
      run($sformatf("rnd%0d", i), ra, re, rn, modpow(longint'(ra), longint'(re), longint'(rn)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
